// File: rtl/relay_credit_pkg.sv
// Shared types and default constants for the credit-based relay sender.
package relay_credit_pkg;

  // Sender control states: INIT loads the credit counter, RUN streams words.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Default receiver buffer depth and pipeline depth.
  localparam int CREDITS_DEF = 8;
  localparam int LEVEL_DEF   = 2;

endpackage

// File: rtl/relay_credit_pipe_stage.sv
// One register stage of the relay: a valid bit with asynchronous reset and a
// data register without reset that only loads when a valid word passes.
module relay_credit_pipe_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  valid_r;
  logic [DATA_WIDTH-1:0] data_r;

  // Valid bit: cleared by reset so in-flight words are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= in_valid;
    end
  end

  // Data register: holds its previous contents when no word is offered.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      data_r <= in_data;
    end else begin
      data_r <= data_r;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;

endmodule

// File: rtl/relay_credit_sender.sv
// Credit-based relay sender: pops an upstream FWFT FIFO while the receiver has
// free slots, forwards words over LEVEL register stages, and counts returned
// credits that travel back over LEVEL register stages.
// Optional feature macro: RELAY_CREDIT_SENDER_ERR_EN (sticky overflow flag).
module relay_credit_sender
  import relay_credit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = CREDITS_DEF,
  parameter int LEVEL      = LEVEL_DEF,
  parameter int CNT_WIDTH  = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_empty_n,
  output logic                  in_read,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  link_valid,
  output logic [DATA_WIDTH-1:0] link_data,
  input  logic                  link_credit,
  output logic [CNT_WIDTH-1:0]  credit_count,
  output logic                  idle,
  output logic                  err
);

  localparam logic [CNT_WIDTH-1:0] CREDITS_C = CNT_WIDTH'(CREDITS);
  localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ZERO_C    = CNT_WIDTH'(0);

  state_t                 state_r;
  state_t                 state_next_s;
  logic [CNT_WIDTH-1:0]   credit_count_r;
  logic [CNT_WIDTH-1:0]   count_next_s;
  logic                   send_s;
  logic                   credit_d_s;
  logic                   pipe_busy_s;

  // Index 0 is the pipeline input; index LEVEL is what leaves the last stage.
  logic [LEVEL:0]         fwd_valid_s;
  logic [DATA_WIDTH-1:0]  fwd_data_s [0:LEVEL];
  logic [LEVEL:0]         crd_valid_s;
  logic [0:0]             crd_data_s [0:LEVEL];

  // A word may only leave when the receiver is known to have a free slot.
  assign send_s  = (state_r == RUN) & in_empty_n & (credit_count_r != ZERO_C);
  assign in_read = send_s;

  assign fwd_valid_s[0] = send_s;
  assign fwd_data_s[0]  = in_dout;
  assign crd_valid_s[0] = link_credit;
  assign crd_data_s[0]  = link_credit;

  for (genvar g = 0; g < LEVEL; g++) begin : g_stage
    relay_credit_pipe_stage #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_fwd (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (fwd_valid_s[g]),
      .in_data   (fwd_data_s[g]),
      .out_valid (fwd_valid_s[g+1]),
      .out_data  (fwd_data_s[g+1])
    );

    relay_credit_pipe_stage #(
      .DATA_WIDTH (1)
    ) u_crd (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (crd_valid_s[g]),
      .in_data   (crd_data_s[g]),
      .out_valid (crd_valid_s[g+1]),
      .out_data  (crd_data_s[g+1])
    );
  end

  assign link_valid = fwd_valid_s[LEVEL];
  assign link_data  = fwd_data_s[LEVEL];
  assign credit_d_s = crd_valid_s[LEVEL] & crd_data_s[LEVEL][0];

  if (LEVEL > 0) begin : g_busy
    assign pipe_busy_s = |fwd_valid_s[LEVEL:1];
  end else begin : g_no_busy
    assign pipe_busy_s = 1'b0;
  end

  // Next state and next credit count; a credit with no free room saturates.
  always_comb begin
    state_next_s = state_r;
    count_next_s = credit_count_r;
    case (state_r)
      INIT: begin
        state_next_s = RUN;
        count_next_s = CREDITS_C;
      end
      RUN: begin
        state_next_s = RUN;
        case ({send_s, credit_d_s})
          2'b10: count_next_s = credit_count_r - ONE_C;
          2'b01: begin
            if (credit_count_r != CREDITS_C) begin
              count_next_s = credit_count_r + ONE_C;
            end else begin
              count_next_s = credit_count_r;
            end
          end
          default: count_next_s = credit_count_r;
        endcase
      end
      default: begin
        state_next_s = INIT;
        count_next_s = CREDITS_C;
      end
    endcase
  end

  // State and credit counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= INIT;
      credit_count_r <= CREDITS_C;
    end else begin
      state_r        <= state_next_s;
      credit_count_r <= count_next_s;
    end
  end

  assign credit_count = credit_count_r;
  assign idle         = (credit_count_r == CREDITS_C) & ~pipe_busy_s;

`ifdef RELAY_CREDIT_SENDER_ERR_EN
  logic overflow_s;
  logic err_r;

  // A returned credit with every slot already counted as free is a protocol error.
  assign overflow_s = (state_r == RUN) & credit_d_s & ~send_s & (credit_count_r == CREDITS_C);

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (overflow_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_relay_credit_sender.sv
// Scoreboard bench for relay_credit_sender (CREDITS = 8, LEVEL = 2).
module tb_relay_credit_sender;

  localparam int DW  = 32;
  localparam int CR  = 8;
  localparam int LV  = 2;
  localparam int CW  = $clog2(CR + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_empty_n;
  logic          in_read;
  logic [DW-1:0] in_dout;
  logic          link_valid;
  logic [DW-1:0] link_data;
  logic          link_credit;
  logic [CW-1:0] credit_count;
  logic          idle;
  logic          err;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            pop_cnt = 0;
  int            recv_cnt = 0;
  logic          echo_en = 1'b0;
  logic          echo_v;
  logic          pop_now;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_data_q[$];
  int            exp_cyc_q[$];
  logic          exp_err;
  int            hits;

  relay_credit_sender #(
    .DATA_WIDTH (DW),
    .CREDITS    (CR),
    .LEVEL      (LV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_empty_n   (in_empty_n),
    .in_read      (in_read),
    .in_dout      (in_dout),
    .link_valid   (link_valid),
    .link_data    (link_data),
    .link_credit  (link_credit),
    .credit_count (credit_count),
    .idle         (idle),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Edge counter used to time-stamp sends and deliveries.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    in_empty_n = (fifo_q.size() != 0);
    in_dout    = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0000_0000;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Upstream FIFO model plus link monitor: record pops, check deliveries.
  initial begin
    forever begin
      @(negedge clk);
      pop_now = in_read;
      if (pop_now) begin
        exp_data_q.push_back(in_dout);
        exp_cyc_q.push_back(cyc);
        pop_cnt++;
      end
      if (link_valid) begin
        recv_cnt++;
        if (exp_data_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL link_unexpected: got word %0h with none expected", link_data);
        end else begin
          chk("link_data", link_data, exp_data_q.pop_front());
          chk("link_latency", cyc - exp_cyc_q.pop_front(), LV);
        end
      end
      @(posedge clk);
      #1;
      if (pop_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
      refresh();
    end
  end

  // Receiver model for steady state: returns a credit one cycle after each word.
  initial begin
    forever begin
      @(negedge clk);
      echo_v = link_valid;
      @(posedge clk);
      #1;
      if (echo_en) link_credit = echo_v;
    end
  end

  initial begin
`ifdef RELAY_CREDIT_SENDER_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset = 1'b1;
    link_credit = 1'b0;
    refresh();
    step(3);
    chk("rst_in_read", in_read, 0);
    chk("rst_link_valid", link_valid, 0);
    chk("rst_count", credit_count, 8);
    chk("rst_err", err, 0);
    chk("rst_idle", idle, 1);
    for (int i = 0; i < 20; i++) fifo_q.push_back(32'hA000_0000 + i);
    refresh();
    #1;
    chk("rst_in_read_data", in_read, 0);

    // Release reset: INIT for one cycle, then RUN.
    step(1);
    reset = 1'b0;
    #1;
    chk("init_in_read", in_read, 0);
    chk("init_count", credit_count, 8);
    step(1);
    chk("run_in_read", in_read, 1);
    chk("run_count", credit_count, 8);

    // Credit exhaustion.
    step(14);
    chk("exh_pops", pop_cnt, 8);
    chk("exh_recv", recv_cnt, 8);
    chk("exh_count", credit_count, 0);
    chk("exh_in_read", in_read, 0);
    chk("exh_idle", idle, 0);

    // Single credit return while exhausted.
    link_credit = 1'b1;
    step(1);
    link_credit = 1'b0;
    chk("ret_count_c1", credit_count, 0);
    step(1);
    chk("ret_count_c2", credit_count, 0);
    step(1);
    chk("ret_count_c3", credit_count, 1);
    chk("ret_in_read_c3", in_read, 1);
    step(1);
    chk("ret_count_c4", credit_count, 0);
    chk("ret_in_read_c4", in_read, 0);
    chk("ret_pops", pop_cnt, 9);

    // Drain upstream, return credits in two bursts, then overflow.
    fifo_q.delete();
    refresh();
    step(4);
    link_credit = 1'b1;
    step(3);
    link_credit = 1'b0;
    step(4);
    chk("part_count", credit_count, 3);
    chk("part_in_read", in_read, 0);
    link_credit = 1'b1;
    step(5);
    link_credit = 1'b0;
    step(4);
    chk("full_count", credit_count, 8);
    chk("full_idle", idle, 1);
    chk("full_err", err, 0);
    link_credit = 1'b1;
    step(1);
    link_credit = 1'b0;
    step(4);
    chk("ovf_count", credit_count, 8);
    chk("ovf_err", err, exp_err);
    step(3);
    chk("ovf_err_hold", err, exp_err);
    chk("ovf_recv", recv_cnt, 9);

    // Steady state with the receiver echoing credits.
    for (int i = 0; i < 100; i++) fifo_q.push_back(32'h5000_0000 + i);
    refresh();
    echo_en = 1'b1;
    #1;
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      if (in_read) hits++;
      step(1);
    end
    chk("steady_hits", hits, 100);
    chk("steady_in_read_end", in_read, 0);
    step(12);
    echo_en = 1'b0;
    link_credit = 1'b0;
    step(2);
    chk("steady_recv", recv_cnt, 109);
    chk("steady_count", credit_count, 8);
    chk("steady_idle", idle, 1);

    // Mid-stream reset with two words in flight.
    for (int i = 0; i < 6; i++) fifo_q.push_back(32'hC000_0000 + i);
    refresh();
    step(2);
    chk("pre_rst_link_valid", link_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_link_valid", link_valid, 0);
    chk("mid_rst_count", credit_count, 8);
    chk("mid_rst_in_read", in_read, 0);
    fifo_q.delete();
    exp_data_q.delete();
    exp_cyc_q.delete();
    refresh();
    step(2);
    reset = 1'b0;
    recv_cnt = 0;
    fifo_q.push_back(32'hD000_0001);
    fifo_q.push_back(32'hD000_0002);
    refresh();
    step(8);
    chk("post_rst_recv", recv_cnt, 2);
    chk("post_rst_count", credit_count, 6);
    chk("post_rst_err", err, 0);
    chk("sb_empty", exp_data_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
